// File: rtl/platform_collision.sv
// platform_collision: once per frame, scans the 90 platform slots one per cycle and reports the first landing under the doodle's feet.
// Defining PLATFORM_COLLISION_INDEX_EN adds the hit_index output.
module platform_collision #(
  parameter int FPS             = 60,
  parameter int CLK             = 25_000_000,
  parameter int PLATFORM_HEIGHT = 30,
  parameter int PLATFORM_WIDTH  = 100,
  parameter int DOODLE_HEIGHT   = 80,
  parameter int DOODLE_WIDTH    = 80
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(CLK/FPS):0]     fps_counter,
  input  logic signed [89:0][1:0][10:0] platforms,
  input  logic [89:0]                  platform_activation,
  input  logic [10:0]                  doodle_x,
  input  logic [9:0]                   doodle_y,
  input  logic                         doodle_falling,
  output logic                         move_collision,
  output logic signed [10:0]           landing_y,
`ifdef PLATFORM_COLLISION_INDEX_EN
  output logic [6:0]                   hit_index,
`endif
  output logic                         busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic signed [11:0] PH1 = 12'(PLATFORM_HEIGHT - 1);
  localparam logic signed [11:0] PW1 = 12'(PLATFORM_WIDTH - 1);
  localparam logic signed [11:0] DH1 = 12'(DOODLE_HEIGHT - 1);
  localparam logic signed [11:0] DW1 = 12'(DOODLE_WIDTH - 1);
  state_t state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic [10:0] dx_q, dx_d;
  logic [9:0] dy_q, dy_d;
  logic fall_q, fall_d, hit_q, hit_d, mc_q, mc_d;
  logic signed [10:0] hit_y_q, hit_y_d, ly_q, ly_d;
`ifdef PLATFORM_COLLISION_INDEX_EN
  logic [6:0] hit_i_q, hit_i_d, hi_q, hi_d;
`endif
  logic tick, slot_hit;
  logic signed [11:0] py, px, feet, dl, dr;
  assign tick = &fps_counter;
  // platform fields are read live at the current index, not snapshotted
  assign py = {platforms[idx_q][0][10], platforms[idx_q][0]};
  assign px = {platforms[idx_q][1][10], platforms[idx_q][1]};
  assign feet = $signed({2'b00, dy_q}) + DH1;
  assign dl = $signed({1'b0, dx_q});
  assign dr = dl + DW1;
  assign slot_hit = platform_activation[idx_q] & fall_q & (py <= feet) & (feet <= py + PH1)
                  & (dr >= px) & (dl <= px + PW1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    dx_d = dx_q;
    dy_d = dy_q;
    fall_d = fall_q;
    hit_d = hit_q;
    hit_y_d = hit_y_q;
    mc_d = mc_q;
    ly_d = ly_q;
`ifdef PLATFORM_COLLISION_INDEX_EN
    hit_i_d = hit_i_q;
    hi_d = hi_q;
`endif
    if (tick) begin
      state_d = SCAN;
      idx_d = '0;
      dx_d = doodle_x;
      dy_d = doodle_y;
      fall_d = doodle_falling;
      hit_d = 1'b0;
      hit_y_d = '0;
`ifdef PLATFORM_COLLISION_INDEX_EN
      hit_i_d = '0;
`endif
    end else if (state_q == SCAN) begin
      if (slot_hit && !hit_q) begin
        hit_d = 1'b1;
        hit_y_d = py[10:0];
`ifdef PLATFORM_COLLISION_INDEX_EN
        hit_i_d = idx_q;
`endif
      end
      idx_d = idx_q + 7'd1;
      state_d = (idx_q == 7'd89) ? DONE : SCAN;
    end else if (state_q == DONE) begin
      mc_d = hit_q;
      ly_d = hit_q ? hit_y_q : '0;
`ifdef PLATFORM_COLLISION_INDEX_EN
      hi_d = hit_q ? hit_i_q : 7'd127;
`endif
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      fall_q <= 1'b0;
      hit_q <= 1'b0;
      hit_y_q <= '0;
      mc_q <= 1'b0;
      ly_q <= '0;
`ifdef PLATFORM_COLLISION_INDEX_EN
      hit_i_q <= '0;
      hi_q <= 7'd127;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      fall_q <= fall_d;
      hit_q <= hit_d;
      hit_y_q <= hit_y_d;
      mc_q <= mc_d;
      ly_q <= ly_d;
`ifdef PLATFORM_COLLISION_INDEX_EN
      hit_i_q <= hit_i_d;
      hi_q <= hi_d;
`endif
    end
  end
  assign move_collision = mc_q;
  assign landing_y = ly_q;
  assign busy = (state_q != IDLE);
`ifdef PLATFORM_COLLISION_INDEX_EN
  assign hit_index = hi_q;
`endif
endmodule
